// File: rtl/egress_checker_pkg.sv
// Shared types for the egress stream checker: FSM states and error codes.
package egress_checker_pkg;

  localparam int unsigned ERR_CODE_BITS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  // Numeric order doubles as priority when several checks fail on one flit.
  typedef enum logic [ERR_CODE_BITS-1:0] {
    ERR_NONE            = 3'd0,
    ERR_NO_HEAD         = 3'd1,
    ERR_UNEXPECTED_HEAD = 3'd2,
    ERR_ID_CHANGE       = 3'd3,
    ERR_PAYLOAD         = 3'd4,
    ERR_TOO_LONG        = 3'd5,
    ERR_TIMEOUT         = 3'd6
  } err_code_t;

endpackage

// File: rtl/egress_stall_gen.sv
// Registered ready generator: STALL_PERIOD ready cycles, then one stall cycle.
module egress_stall_gen #(
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic clock,
  input  logic reset,
  output logic ready
);

  if (STALL_PERIOD == 0) begin : g_always_ready
    always_ff @(posedge clock) begin
      if (reset) ready <= 1'b0;
      else       ready <= 1'b1;
    end
  end else begin : g_periodic_stall
    localparam int unsigned CNT_BITS = $clog2(STALL_PERIOD + 1);

    logic [CNT_BITS-1:0] cnt;

    // cnt counts the ready cycles already issued in the current period.
    always_ff @(posedge clock) begin
      if (reset) begin
        ready <= 1'b0;
        cnt   <= '0;
      end else if (cnt == CNT_BITS'(STALL_PERIOD)) begin
        ready <= 1'b0;
        cnt   <= '0;
      end else begin
        ready <= 1'b1;
        cnt   <= cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/egress_stream_checker.sv
// NoC egress endpoint: backpressure, framing/payload checks and latency stats.
module egress_stream_checker
  import egress_checker_pkg::*;
#(
  parameter int unsigned EGRESS_ID        = 0,
  parameter int unsigned INGRESS_BITS     = 8,
  parameter int unsigned CYCLE_COUNT_BITS = 64,
  parameter int unsigned PAYLOAD_BITS     = 64,
  parameter int unsigned MAX_FLITS        = 16,
  parameter int unsigned EXPECTED_PACKETS = 32,
  parameter int unsigned STALL_PERIOD     = 0,
  parameter int unsigned TIMEOUT          = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CYCLE_COUNT_BITS-1:0] cycle_count,
  input  logic                        flit_in_valid,
  output logic                        flit_in_ready,
  input  logic                        flit_in_head,
  input  logic                        flit_in_tail,
  input  logic [INGRESS_BITS-1:0]     flit_in_ingress_id,
  input  logic [PAYLOAD_BITS-1:0]     flit_in_payload,
  output logic [15:0]                 packets_received,
  output logic [CYCLE_COUNT_BITS-1:0] max_latency,
  output logic                        error,
  output logic [ERR_CODE_BITS-1:0]    error_code,
  output logic                        success
);

  localparam int unsigned K_BITS    = $clog2(MAX_FLITS + 1);
  localparam int unsigned IDLE_BITS = $clog2(TIMEOUT + 1);
  localparam int unsigned PKT_BITS  = 16;

  if (PAYLOAD_BITS < CYCLE_COUNT_BITS) begin : g_bad_payload_width
    $error("PAYLOAD_BITS must be at least CYCLE_COUNT_BITS");
  end
  if (EGRESS_ID > 32'h7FFF_FFFF) begin : g_bad_egress_id
    $error("EGRESS_ID must fit a signed 32-bit report field");
  end

  state_t                      state_q, state_d;
  logic [K_BITS-1:0]           k_q, k_d;
  logic [INGRESS_BITS-1:0]     id_q, id_d;
  logic [CYCLE_COUNT_BITS-1:0] inj_q, inj_d, inj_src, latency;
  logic [IDLE_BITS-1:0]        idle_q, idle_d;
  logic [PKT_BITS-1:0]         pkts_d;
  logic [CYCLE_COUNT_BITS-1:0] max_lat_d;
  logic                        error_d, overrun_q, overrun_d, success_d;
  logic [ERR_CODE_BITS-1:0]    code_d;
  err_code_t                   fault;
  logic                        fire, complete;

  egress_stall_gen #(
    .STALL_PERIOD(STALL_PERIOD)
  ) u_stall_gen (
    .clock(clock),
    .reset(reset),
    .ready(flit_in_ready)
  );

  assign fire = flit_in_valid & flit_in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      k_q              <= '0;
      id_q             <= '0;
      inj_q            <= '0;
      idle_q           <= '0;
      overrun_q        <= 1'b0;
      packets_received <= '0;
      max_latency      <= '0;
      error            <= 1'b0;
      error_code       <= '0;
      success          <= 1'b0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      id_q             <= id_d;
      inj_q            <= inj_d;
      idle_q           <= idle_d;
      overrun_q        <= overrun_d;
      packets_received <= pkts_d;
      max_latency      <= max_lat_d;
      error            <= error_d;
      error_code       <= code_d;
      success          <= success_d;
    end
  end

  // Framing FSM, error capture and completion bookkeeping.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    id_d      = id_q;
    inj_d     = inj_q;
    idle_d    = idle_q;
    overrun_d = overrun_q;
    pkts_d    = packets_received;
    max_lat_d = max_latency;
    error_d   = error;
    code_d    = error_code;
    fault     = ERR_NONE;
    complete  = 1'b0;
    inj_src   = (state_q == IDLE) ? flit_in_payload[CYCLE_COUNT_BITS-1:0] : inj_q;
    latency   = cycle_count - inj_src;

    if (fire) begin
      idle_d = '0;
      if (state_q == IDLE) begin
        if (!flit_in_head) begin
          fault = ERR_NO_HEAD;
        end else begin
          id_d  = flit_in_ingress_id;
          inj_d = inj_src;
          k_d   = K_BITS'(1);
          if (flit_in_tail) complete = 1'b1;
          else              state_d  = BODY;
        end
      end else begin
        if (flit_in_head)                                       fault = ERR_UNEXPECTED_HEAD;
        else if (flit_in_ingress_id != id_q)                    fault = ERR_ID_CHANGE;
        else if (flit_in_payload != PAYLOAD_BITS'(k_q))         fault = ERR_PAYLOAD;
        else if (!flit_in_tail && k_q == K_BITS'(MAX_FLITS - 1)) fault = ERR_TOO_LONG;
        else if (flit_in_tail) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          k_d = k_q + K_BITS'(1);
        end
      end
    end else if (state_q == BODY) begin
      if (idle_q == IDLE_BITS'(TIMEOUT - 1)) fault  = ERR_TIMEOUT;
      else                                   idle_d = idle_q + IDLE_BITS'(1);
    end

    // Any error abandons the open packet; only the first one is recorded.
    if (fault != ERR_NONE) begin
      state_d = IDLE;
      k_d     = '0;
      idle_d  = '0;
      if (!error) begin
        error_d = 1'b1;
        code_d  = fault;
      end
    end

    if (complete) begin
      k_d = '0;
      if (packets_received >= PKT_BITS'(EXPECTED_PACKETS)) overrun_d = 1'b1;
      if (packets_received != '1) pkts_d = packets_received + PKT_BITS'(1);
      if (latency > max_latency) max_lat_d = latency;
    end

    success_d = (pkts_d == PKT_BITS'(EXPECTED_PACKETS)) && !error_d && !overrun_d
                && (state_d == IDLE);
  end

endmodule

// File: tb/tb_egress_stream_checker.sv
// Scoreboarded random bench for egress_stream_checker (stalling and non-stalling instances).
module tb_egress_stream_checker;

  localparam int unsigned IB    = 8;
  localparam int unsigned CB    = 64;
  localparam int unsigned PB    = 64;
  localparam int unsigned MAXF  = 16;
  localparam int unsigned EXP   = 32;
  localparam int unsigned STALL = 3;
  localparam int unsigned TMO   = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic [CB-1:0] cycle_count;
  logic          valid, valid0, head, tail;
  logic [IB-1:0] id;
  logic [PB-1:0] payload;
  logic [63:0]   tick = 64'd0;
  logic [63:0]   offset = 64'd0;

  logic          ready3, err3, suc3, ready0, err0, suc0;
  logic [15:0]   pr3, pr0;
  logic [CB-1:0] ml3, ml0;
  logic [2:0]    code3, code0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) tick <= tick + 64'd1;
  assign cycle_count = tick + offset;

  egress_stream_checker #(
    .EGRESS_ID(1), .INGRESS_BITS(IB), .CYCLE_COUNT_BITS(CB), .PAYLOAD_BITS(PB),
    .MAX_FLITS(MAXF), .EXPECTED_PACKETS(EXP), .STALL_PERIOD(STALL), .TIMEOUT(TMO)
  ) u_dut3 (
    .clock(clock), .reset(reset), .cycle_count(cycle_count),
    .flit_in_valid(valid), .flit_in_ready(ready3), .flit_in_head(head), .flit_in_tail(tail),
    .flit_in_ingress_id(id), .flit_in_payload(payload),
    .packets_received(pr3), .max_latency(ml3), .error(err3), .error_code(code3), .success(suc3)
  );

  egress_stream_checker #(
    .EGRESS_ID(2), .INGRESS_BITS(IB), .CYCLE_COUNT_BITS(CB), .PAYLOAD_BITS(PB),
    .MAX_FLITS(MAXF), .EXPECTED_PACKETS(EXP), .STALL_PERIOD(0), .TIMEOUT(TMO)
  ) u_dut0 (
    .clock(clock), .reset(reset), .cycle_count(cycle_count),
    .flit_in_valid(valid0), .flit_in_ready(ready0), .flit_in_head(head), .flit_in_tail(tail),
    .flit_in_ingress_id(id), .flit_in_payload(payload),
    .packets_received(pr0), .max_latency(ml0), .error(err0), .error_code(code0), .success(suc0)
  );

  typedef struct {
    logic        ready;
    logic        ready0;
    logic [15:0] pr;
    logic [63:0] ml;
    logic        err;
    logic [2:0]  code;
    logic        success;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: packet-level view of the stream.
  int          n_out;
  bit          m_ready;
  bit          open;
  logic [7:0]  pid;
  logic [63:0] pinj;
  int          nfl, idle, m_pr, m_code;
  logic [63:0] m_ml;
  bit          m_err, extra, m_suc;

  task automatic complete_pkt(input logic [63:0] lat);
    if (m_pr >= int'(EXP)) extra = 1'b1;
    if (m_pr < 65535) m_pr = m_pr + 1;
    if (lat > m_ml) m_ml = lat;
  endtask

  always @(posedge clock) begin
    bit   fire;
    int   c;
    int   cands[$];
    exp_t e;
    if (reset) begin
      n_out = 0; m_ready = 1'b0; open = 1'b0; nfl = 0; idle = 0; m_pr = 0;
      m_ml = 64'd0; m_err = 1'b0; m_code = 0; extra = 1'b0; m_suc = 1'b0;
    end else begin
      fire = valid && m_ready;
      c = 0;
      if (fire) begin
        if (!open) begin
          if (!head) c = 1;
          else if (tail) complete_pkt(cycle_count - payload[CB-1:0]);
          else begin
            open = 1'b1; pid = id; pinj = payload[CB-1:0]; nfl = 1; idle = 0;
          end
        end else begin
          cands = {};
          if (head) cands.push_back(2);
          if (id != pid) cands.push_back(3);
          if (payload != 64'(nfl)) cands.push_back(4);
          if (!tail && nfl + 1 == int'(MAXF)) cands.push_back(5);
          if (cands.size() > 0) begin
            c = 7;
            foreach (cands[i]) if (cands[i] < c) c = cands[i];
          end else if (tail) begin
            complete_pkt(cycle_count - pinj);
            open = 1'b0;
          end else begin
            nfl = nfl + 1;
            idle = 0;
          end
        end
      end else if (open) begin
        idle = idle + 1;
        if (idle == int'(TMO)) c = 6;
      end
      if (c != 0) begin
        open = 1'b0;
        if (!m_err) begin m_err = 1'b1; m_code = c; end
      end
      n_out = n_out + 1;
      m_ready = (n_out % (STALL + 1)) != 0;
      m_suc = (m_pr == int'(EXP)) && !m_err && !open && !extra;
    end
    e.ready = m_ready; e.ready0 = (n_out > 0); e.pr = 16'(m_pr); e.ml = m_ml;
    e.err = m_err; e.code = 3'(m_code); e.success = m_suc;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every registered output of both instances against the model.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("s3_ready", 64'(ready3), 64'(e.ready));
      chk("s3_packets", 64'(pr3), 64'(e.pr));
      chk("s3_max_latency", ml3, e.ml);
      chk("s3_error", 64'(err3), 64'(e.err));
      chk("s3_error_code", 64'(code3), 64'(e.code));
      chk("s3_success", 64'(suc3), 64'(e.success));
      chk("s0_ready", 64'(ready0), 64'(e.ready0));
      chk("s0_packets", 64'(pr0), 64'(e.pr));
      chk("s0_max_latency", ml0, e.ml);
      chk("s0_error", 64'(err0), 64'(e.err));
      chk("s0_error_code", 64'(code0), 64'(e.code));
      chk("s0_success", 64'(suc0), 64'(e.success));
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clock);
      valid = 1'b0; valid0 = 1'b0;
    end
  endtask

  task automatic junk();
    valid = 1'($urandom); valid0 = 1'b0;
    head = 1'($urandom); tail = 1'($urandom); id = IB'($urandom);
    payload = {32'($urandom), 32'($urandom)};
  endtask

  // Presents one flit on a cycle the model predicts as ready; junk fills stall cycles.
  task automatic send(input bit h, input bit t, input logic [IB-1:0] i,
                      input logic [PB-1:0] p, input bit rel);
    for (int tries = 0; tries < 4; tries++) begin
      @(negedge clock);
      if (m_ready) begin
        valid = 1'b1; valid0 = 1'b1; head = h; tail = t; id = i;
        payload = rel ? (cycle_count - p) : p;
        break;
      end
      junk();
    end
  endtask

  task automatic send_packet(input int len, input logic [IB-1:0] i, input int delta);
    for (int k = 0; k < len; k++) begin
      send(k == 0, k == len - 1, i, (k == 0) ? PB'(delta) : PB'(k), k == 0);
      if ($urandom_range(3) == 0) idle_cycles(int'($urandom_range(2, 1)));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1; valid = 1'b0; valid0 = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int len;
    reset = 1'b1; valid = 1'b0; valid0 = 1'b0; head = 1'b0; tail = 1'b0;
    id = '0; payload = '0;
    do_reset(3);

    for (int i = 0; i < 32; i++) begin
      len = (i % 8 == 0) ? 16 : (i % 8 == 1) ? 1 : 4;
      send_packet(len, IB'($urandom), 10 + int'($urandom_range(19)));
    end
    idle_cycles(3);
    chk("success_after_burst", 64'(suc3), 64'd1);
    chk("packets_after_burst", 64'(pr3), 64'd32);
    chk("max_latency_ge_13", 64'(ml3 >= 64'd13), 64'd1);
    send_packet(4, 8'h11, 10);
    idle_cycles(3);
    chk("success_cleared_extra", 64'(suc3), 64'd0);

    do_reset(1);
    send(1'b0, 1'b1, 8'h05, 64'd1, 1'b0);
    idle_cycles(2);
    chk("no_head_code", 64'(code3), 64'd1);

    do_reset(1);
    send(1'b1, 1'b0, 8'h21, 64'd10, 1'b1);
    send(1'b0, 1'b0, 8'h21, 64'd1, 1'b0);
    send(1'b0, 1'b0, 8'h21, 64'd7, 1'b0);
    idle_cycles(2);
    chk("payload_code", 64'(code3), 64'd4);

    do_reset(1);
    send(1'b1, 1'b0, 8'h31, 64'd10, 1'b1);
    send(1'b0, 1'b0, 8'h31, 64'd1, 1'b0);
    send(1'b1, 1'b0, 8'h31, 64'd9, 1'b0);
    send(1'b0, 1'b1, 8'h31, 64'd3, 1'b0);
    idle_cycles(2);
    chk("head_beats_payload_code", 64'(code3), 64'd2);

    do_reset(1);
    send(1'b1, 1'b0, 8'h03, 64'd10, 1'b1);
    send(1'b0, 1'b0, 8'h04, 64'd9, 1'b0);
    idle_cycles(2);
    chk("id_change_code", 64'(code3), 64'd3);

    do_reset(1);
    send_packet(16, 8'h44, 12);
    idle_cycles(2);
    chk("max_len_ok_packets", 64'(pr3), 64'd1);
    send(1'b1, 1'b0, 8'h45, 64'd10, 1'b1);
    for (int k = 1; k < 16; k++) send(1'b0, 1'b0, 8'h45, 64'(k), 1'b0);
    idle_cycles(2);
    chk("too_long_code", 64'(code3), 64'd5);

    do_reset(1);
    send(1'b1, 1'b0, 8'h66, 64'd10, 1'b1);
    send(1'b0, 1'b0, 8'h66, 64'd1, 1'b0);
    idle_cycles(25);
    chk("timeout_code", 64'(code3), 64'd6);
    do_reset(1);
    idle_cycles(1);
    chk("reset_error", 64'(err3), 64'd0);
    chk("reset_code", 64'(code3), 64'd0);

    do_reset(1);
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      if (m_ready) begin
        offset = 64'd5 - tick;
        valid = 1'b1; valid0 = 1'b1; head = 1'b1; tail = 1'b1; id = 8'h77;
        payload = 64'hFFFF_FFFF_FFFF_FFFD;
        break;
      end
      valid = 1'b0; valid0 = 1'b0;
    end
    idle_cycles(2);
    chk("wrap_latency", ml3, 64'd8);
    @(negedge clock);
    offset = 64'd0 - tick - 64'd2;
    send_packet(4, 8'h78, 0);
    idle_cycles(2);

    do_reset(1);
    offset = 64'd0;
    for (int i = 0; i < 40; i++) begin
      len = int'($urandom_range(MAXF, 1));
      if ($urandom_range(15) == 0) begin
        send(1'b1, 1'b0, 8'h90, 64'd5, 1'b1);
        send(1'b0, 1'b1, 8'h90, 64'd2, 1'b0);
      end else begin
        send_packet(len, IB'($urandom), int'($urandom_range(40)));
      end
    end
    idle_cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
